// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI-lite initiator. Turns one CPU load/store
// request into one AXI-lite read (AR/R) or write (AW/W/B) transaction and returns
// a one-cycle completion pulse. All AXI and response outputs come from registers.
module axi_lite_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              aclk,
  input  logic              areset,
  // CPU request/response side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  // AXI-lite read address / data
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // AXI-lite write address / data / response
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [7:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t              state_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                resp_err_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic                awvalid_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          wstrb_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                aw_done_d;
  logic                w_done_d;

  // A channel counts as done if it was already done or handshakes this cycle,
  // so AW and W may finish together or in either order.
  assign aw_done_d = aw_done_q | (awvalid_q & awready);
  assign w_done_d  = w_done_q  | (wvalid_q  & wready);

  // Transaction sequencer with registered AXI and response outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (req_wen) begin
              awaddr_q  <= req_addr;
              wdata_q   <= req_wdata;
              wstrb_q   <= req_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              araddr_q  <= req_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready_q     <= 1'b0;
            resp_rdata_q <= rdata;
            resp_err_q   <= rresp[1];
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        WR_REQ: begin
          awvalid_q <= ~aw_done_d;
          wvalid_q  <= ~w_done_d;
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bready_q  <= 1'b1;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_q     <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= bresp[1];
            resp_valid_q <= 1'b1;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign awaddr     = awaddr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wvalid     = wvalid_q;
  assign bready     = bready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Testbench for axi_lite_master: directed table of transactions plus randomized
// transactions, driven through a wait-state-configurable responder and checked
// cycle by cycle against expected handshake windows and response values.
module tb_axi_lite_master;

  logic        aclk;
  logic        areset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // One transaction: request fields, responder wait states, and expectations.
  // Waits count cycles the responder holds ready/valid low after the DUT side is up.
  typedef struct {
    bit          chain;     // presented in the completion cycle of the previous one
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } txn_t;

  function automatic txn_t mk(input bit chain, input bit wen, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [7:0] ws,
                              input int ar_w, input int r_w, input int aw_w, input int w_w,
                              input int b_w, input logic [1:0] resp, input logic [31:0] rd,
                              input int lat, input logic [31:0] er, input bit ee);
    txn_t t;
    t.chain = chain; t.wen = wen; t.addr = addr; t.wdata = wd; t.wstrb = ws;
    t.ar_w = ar_w; t.r_w = r_w; t.aw_w = aw_w; t.w_w = w_w; t.b_w = b_w;
    t.resp = resp; t.rdata = rd;
    t.exp_lat = lat; t.exp_rdata = er; t.exp_err = ee;
    return t;
  endfunction

  // Reference model: latency is request cycle + address phase + data/response
  // phase + registered completion, stretched by the responder's wait states.
  function automatic txn_t model(input txn_t t);
    txn_t r;
    int   m;
    r = t;
    if (t.wen) begin
      m = (t.aw_w > t.w_w) ? t.aw_w : t.w_w;
      r.exp_lat   = 3 + m + t.b_w;
      r.exp_rdata = 32'h0;
    end else begin
      r.exp_lat   = 3 + t.ar_w + t.r_w;
      r.exp_rdata = t.rdata;
    end
    r.exp_err = t.resp[1];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic present(input txn_t t);
    req_valid = 1'b1;
    req_wen   = t.wen;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_wstrb = t.wstrb;
  endtask

  task automatic responder_idle();
    arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    rdata = $urandom; rresp = 2'($urandom); bresp = 2'($urandom);
  endtask

  // Runs one transaction from its request cycle (c=0) to its completion cycle.
  // Entered and left at #1 after a rising edge. When chained, c=0 was the
  // previous transaction's completion cycle and is skipped here.
  task automatic run_txn(input txn_t t, input bit has_next, input txn_t nt);
    int ar_c, r_c, aw_c, w_c, b_c, m, lat;
    logic [6:0] exp_v, act_v;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    m   = (t.aw_w > t.w_w) ? t.aw_w : t.w_w;
    lat = t.exp_lat;
    for (int c = (t.chain ? 1 : 0); c <= lat; c++) begin
      responder_idle();
      if (arvalid) begin arready = (ar_c == t.ar_w); ar_c++; end
      if (rready) begin
        rvalid = (r_c == t.r_w); r_c++;
        if (rvalid) begin rdata = t.rdata; rresp = t.resp; end
      end
      if (awvalid) begin awready = (aw_c == t.aw_w); aw_c++; end
      if (wvalid)  begin wready  = (w_c  == t.w_w);  w_c++;  end
      if (bready) begin
        bvalid = (b_c == t.b_w); b_c++;
        if (bvalid) bresp = t.resp;
      end
      if (c == lat) begin
        if (has_next && nt.chain) present(nt);
        else req_valid = 1'b0;
      end else if (c >= 1) begin
        // Junk requests while busy must be ignored.
        req_valid = 1'($urandom); req_wen = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_wstrb = 8'($urandom);
      end
      @(negedge aclk);
      if (t.wen)
        exp_v = {(c == 0 || c == lat), 1'b0, 1'b0,
                 (c >= 1 && c <= 1 + t.aw_w), (c >= 1 && c <= 1 + t.w_w),
                 (c >= 2 + m && c < lat), (c == lat)};
      else
        exp_v = {(c == 0 || c == lat), (c >= 1 && c <= 1 + t.ar_w),
                 (c >= 2 + t.ar_w && c < lat), 1'b0, 1'b0, 1'b0, (c == lat)};
      act_v = {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid};
      chk($sformatf("ctrl c=%0d {rq,ar,r,aw,w,b,rsp}", c), 64'(act_v), 64'(exp_v));
      if (arvalid) chk("araddr", 64'(araddr), 64'(t.addr));
      if (awvalid) chk("awaddr", 64'(awaddr), 64'(t.addr));
      if (wvalid) begin
        chk("wdata", 64'(wdata), 64'(t.wdata));
        chk("wstrb", 64'(wstrb), 64'(t.wstrb));
      end
      if (c == lat) begin
        chk("resp_rdata", 64'(resp_rdata), 64'(t.exp_rdata));
        chk("resp_err", 64'(resp_err), 64'(t.exp_err));
      end
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tbl[7];
    txn_t q[$];
    txn_t t, blank, last;

    tbl[0] = mk(0, 0, 32'h8000_0000, 32'h0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 0);
    tbl[1] = mk(0, 0, 32'h1000_0004, 32'h0, 8'h00, 4, 3, 0, 0, 0, 2'd1, 32'hCAFE_F00D, 10, 32'hCAFE_F00D, 0);
    tbl[2] = mk(0, 1, 32'h4000_0100, 32'h1234_5678, 8'h0F, 0, 0, 0, 3, 1, 2'd0, 32'h5555_AAAA, 7, 32'h0, 0);
    tbl[3] = mk(0, 1, 32'h4000_0200, 32'h9ABC_DEF0, 8'hF0, 0, 0, 2, 0, 0, 2'd2, 32'h0, 5, 32'h0, 1);
    tbl[4] = mk(1, 0, 32'h2000_0010, 32'h0, 8'h00, 0, 0, 0, 0, 0, 2'd3, 32'h0BAD_C0DE, 3, 32'h0BAD_C0DE, 1);
    tbl[5] = mk(0, 1, 32'h0000_0008, 32'hFFFF_0000, 8'hFF, 0, 0, 0, 0, 2, 2'd1, 32'h0, 5, 32'h0, 0);
    tbl[6] = mk(1, 0, 32'h0000_000C, 32'h0, 8'h00, 1, 0, 0, 0, 0, 2'd2, 32'h7777_1111, 4, 32'h7777_1111, 1);
    foreach (tbl[i]) q.push_back(tbl[i]);
    for (int i = 0; i < 40; i++) begin
      t = mk(1'($urandom), 1'($urandom), $urandom, $urandom, 8'($urandom),
             int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
             int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
             int'($urandom_range(3, 0)), 2'($urandom), $urandom, 0, 32'h0, 0);
      q.push_back(model(t));
    end
    blank = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);

    // Reset state
    areset = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    responder_idle();
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    chk("rst ctrl", 64'({req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready}), 64'h0);
    chk("rst araddr", 64'(araddr), 64'h0);
    chk("rst awaddr", 64'(awaddr), 64'h0);
    chk("rst wdata/wstrb", {wdata, 24'h0, wstrb}, 64'h0);
    chk("rst resp_rdata", 64'(resp_rdata), 64'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("req_ready in release cycle", 64'(req_ready), 64'h0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("req_ready after release", 64'(req_ready), 64'h1);
    @(posedge aclk); #1;

    // Directed table followed by randomized transactions
    for (int i = 0; i < q.size(); i++) begin
      t = q[i];
      if (!t.chain) begin
        req_valid = 1'b0;
        responder_idle();
        repeat ($urandom_range(2, 0)) begin @(posedge aclk); #1; end
        present(t);
      end
      if (i + 1 < q.size()) run_txn(t, 1'b1, q[i + 1]);
      else run_txn(t, 1'b0, blank);
      last = t;
    end

    // Response fields hold after the completion pulse
    req_valid = 1'b0;
    responder_idle();
    @(negedge aclk);
    chk("resp_valid single pulse", 64'(resp_valid), 64'h0);
    chk("resp_rdata held", 64'(resp_rdata), 64'(last.exp_rdata));
    chk("resp_err held", 64'(resp_err), 64'(last.exp_err));
    @(posedge aclk); #1;

    // Reset while in RD_DATA aborts with no response
    t = mk(0, 0, 32'h3000_0040, 32'h0, 8'h00, 0, 0, 0, 0, 0, 2'd0, 32'h1111_2222, 3, 32'h1111_2222, 0);
    present(t);
    @(posedge aclk); #1;
    req_valid = 1'b0;
    arready = 1'b1;
    @(posedge aclk); #1;
    arready = 1'b0;
    @(negedge aclk);
    chk("rd_data before reset: rready", 64'(rready), 64'h1);
    areset = 1'b1;
    @(posedge aclk); #1;
    rvalid = 1'b1; rdata = 32'hFFFF_FFFF; rresp = 2'd2;
    @(negedge aclk);
    chk("abort ctrl", 64'({req_ready, resp_valid, resp_err, arvalid, rready, awvalid, wvalid, bready}), 64'h0);
    chk("abort araddr", 64'(araddr), 64'h0);
    chk("abort resp_rdata", 64'(resp_rdata), 64'h0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("abort release: resp_valid", 64'(resp_valid), 64'h0);
    @(posedge aclk); #1;
    rvalid = 1'b0;
    @(negedge aclk);
    chk("abort: req_ready after release", 64'(req_ready), 64'h1);
    chk("abort: no response", 64'({resp_valid, rready, arvalid}), 64'h0);
    @(posedge aclk); #1;
    responder_idle();
    present(t);
    run_txn(t, 1'b0, blank);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
